// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU, with a registered one-hot response.
// Optional ALU_ARB_FIXED_PRIO_EN: req0 always wins contention; otherwise round-robin.
module alu_arbiter #(
    parameter int DW    = 32,
    parameter int SEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [2*SEL_W-1:0] req_sel_i,
    input  logic [2*DW-1:0]    req_a_i,
    input  logic [2*DW-1:0]    req_b_i,
    output logic [SEL_W-1:0]   alu_sel_o,
    output logic [DW-1:0]      alu_a_o,
    output logic [DW-1:0]      alu_b_o,
    input  logic [DW-1:0]      alu_res_i,
    output logic [1:0]         rsp_valid_o,
    output logic [DW-1:0]      rsp_data_o,
    input  logic [1:0]         rsp_ready_i
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t     state;
    logic       rsp_accept;
    logic       can_issue;
    logic [1:0] gnt;
    logic [1:0] hs;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic       last_gnt;
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        rsp_accept = |(rsp_valid_o & rsp_ready_i);
        can_issue  = (state == IDLE) || rsp_accept;
        gnt        = 2'b00;
        if (!rst && can_issue) begin
            case (req_valid_i)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
                2'b11:   gnt = 2'b01;
`else
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
`endif
                default: gnt = 2'b00;
            endcase
        end
    end

    assign req_ready_o = gnt;
    assign hs          = req_valid_i & gnt;

    // With no grant the bus falls back to req0 so the ALU never sees X.
    assign alu_sel_o = gnt[1] ? req_sel_i[2*SEL_W-1:SEL_W] : req_sel_i[SEL_W-1:0];
    assign alu_a_o   = gnt[1] ? req_a_i[2*DW-1:DW]         : req_a_i[DW-1:0];
    assign alu_b_o   = gnt[1] ? req_b_i[2*DW-1:DW]         : req_b_i[DW-1:0];

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the result register is reset too, so rsp_data_o reads 0 rather than X after reset.
            state       <= IDLE;
            rsp_valid_o <= 2'b00;
            rsp_data_o  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_gnt    <= 1'b1;
`endif
        end else if (|hs) begin
            // A new issue may coincide with the old response being accepted: no bubble.
            state       <= RESP;
            rsp_valid_o <= hs;
            rsp_data_o  <= alu_res_i;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_gnt    <= hs[1];
`endif
        end else if (rsp_accept) begin
            state       <= IDLE;
            rsp_valid_o <= 2'b00;
        end
    end

endmodule
